// File: rtl/uart_pkg.sv
// Shared UART package: scheduler state encoding, id width, default header tag
// and a modular-increment helper for round-robin pointers.
package uart_pkg;

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA} tx_sched_st_t;

  localparam int         UART_ID_W         = 3;
  localparam logic [4:0] UART_HDR_TAG_DFLT = 5'h1A;

  function automatic logic [UART_ID_W-1:0] wrap_inc(input logic [UART_ID_W-1:0] id,
                                                    input int n);
    int s;
    s = int'(id) + 1;
    if (s >= n) s = 0;
    return UART_ID_W'(s);
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
// Rotate so ptr sits at bit 0, priority-encode, then rotate the index back.
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]           req,
  input  logic [UART_ID_W-1:0]   ptr,
  output logic [UART_ID_W-1:0]   idx,
  output logic                   any
);

  logic [N-1:0]         rot;
  logic [UART_ID_W-1:0] enc;
  logic                 found;

  // ptr is always < N, so a double-width shift is a true rotate
  assign rot = N'({req, req} >> ptr);
  assign any = |req;

  always_comb begin
    enc   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (rot[i] && !found) begin
        enc   = UART_ID_W'(i);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    int s;
    s = int'(enc) + int'(ptr);
    if (s >= N) s = s - N;
    idx = UART_ID_W'(s);
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART_TX between N byte sources: packet-granular round-robin,
// optional id header byte, and a stall watchdog while a packet is granted.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int         N       = 4,
  parameter bit         HDR_EN  = 1'b1,
  parameter logic [4:0] HDR_TAG = UART_HDR_TAG_DFLT,
  parameter int         TIMEOUT = 1024,
  parameter int         TW      = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_vld,
  input  logic [8*N-1:0]       req_dat,
  input  logic [N-1:0]         req_last,
  output logic [N-1:0]         req_rdy,
  output logic                 tx_vld,
  output logic [7:0]           tx_dat,
  input  logic                 tx_bsy,
  output logic [UART_ID_W-1:0] gnt_id,
  output logic                 gnt_act,
  output logic                 err_to,
  output logic [UART_ID_W-1:0] err_id
);

  localparam int            MAXN     = 1 << UART_ID_W;
  localparam logic [TW-1:0] WDOG_MAX = TW'(TIMEOUT - 1);

  tx_sched_st_t         state_reg, state_next;
  logic [UART_ID_W-1:0] ptr_reg, gnt_id_reg, err_id_reg, pick_id;
  logic                 gnt_act_reg, issued_q, pick_any;
  logic [TW-1:0]        wdog_reg;

  logic [MAXN-1:0]      vld_pad, last_pad;
  logic [7:0]           dat_arr [MAXN];
  logic                 cur_vld, cur_last, can_issue, accept, wdog_hit, rdy_any;
  logic [7:0]           cur_dat;

  // Pad the requester buckets to the full id range so gnt_id can index directly
  generate
    for (genvar gi = 0; gi < MAXN; gi++) begin : g_pad
      if (gi < N) begin : g_used
        assign vld_pad[gi]  = req_vld[gi];
        assign last_pad[gi] = req_last[gi];
        assign dat_arr[gi]  = req_dat[8*gi +: 8];
      end else begin : g_unused
        assign vld_pad[gi]  = 1'b0;
        assign last_pad[gi] = 1'b0;
        assign dat_arr[gi]  = 8'h00;
      end
    end
    for (genvar gi = 0; gi < N; gi++) begin : g_rdy
      assign req_rdy[gi] = rdy_any & (gnt_id_reg == UART_ID_W'(gi));
    end
  endgenerate

  uart_rr_pick #(.N(N)) u_pick (
    .req (req_vld),
    .ptr (ptr_reg),
    .idx (pick_id),
    .any (pick_any)
  );

  assign cur_vld   = vld_pad[gnt_id_reg];
  assign cur_last  = last_pad[gnt_id_reg];
  assign cur_dat   = dat_arr[gnt_id_reg];
  // The gap after each issue gives UART_TX's registered bsy time to rise
  assign can_issue = ~tx_bsy & ~issued_q;
  assign accept    = rdy_any & cur_vld;
  assign wdog_hit  = (TIMEOUT != 0) && (state_reg == S_DATA) &&
                     (wdog_reg == WDOG_MAX) && !accept;
  assign err_to    = wdog_hit & ~rst;

  assign gnt_id  = gnt_id_reg;
  assign gnt_act = gnt_act_reg;
  assign err_id  = err_id_reg;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (pick_any) state_next = HDR_EN ? S_HDR : S_DATA;
      S_HDR:  if (can_issue) state_next = S_DATA;
      S_DATA: if ((accept && cur_last) || wdog_hit) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    tx_vld  = 1'b0;
    tx_dat  = 8'h00;
    rdy_any = 1'b0;
    case (state_reg)
      S_HDR: begin
        tx_vld = can_issue & ~rst;
        tx_dat = {HDR_TAG, gnt_id_reg};
      end
      S_DATA: begin
        rdy_any = can_issue & ~rst;
        tx_vld  = can_issue & cur_vld & ~rst;
        tx_dat  = cur_dat;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg     <= '0;
      gnt_id_reg  <= '0;
      gnt_act_reg <= 1'b0;
      err_id_reg  <= '0;
      wdog_reg    <= '0;
      issued_q    <= 1'b0;
    end else begin
      issued_q <= tx_vld;
      case (state_reg)
        S_IDLE: begin
          if (pick_any) begin
            gnt_id_reg  <= pick_id;
            gnt_act_reg <= 1'b1;
            wdog_reg    <= '0;
          end
        end
        S_DATA: begin
          if (accept) begin
            wdog_reg <= '0;
            if (cur_last) begin
              gnt_act_reg <= 1'b0;
              ptr_reg     <= wrap_inc(gnt_id_reg, N);
            end
          end else if (wdog_hit) begin
            // Abandon the packet; its remaining bytes come back as a fresh packet
            err_id_reg  <= gnt_id_reg;
            gnt_act_reg <= 1'b0;
            ptr_reg     <= wrap_inc(gnt_id_reg, N);
            wdog_reg    <= '0;
          end else if (!cur_vld) begin
            wdog_reg <= wdog_reg + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: per-port packet queues drive the requesters, an
// expected byte stream plus protocol rules are checked every cycle.
module tb_uart_tx_sched;

  localparam int         N   = 4;
  localparam int         TO  = 16;
  localparam logic [4:0] TAG = 5'h1A;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_vld, req_last, req_rdy;
  logic [8*N-1:0] req_dat;
  logic           tx_vld, tx_bsy, gnt_act, err_to;
  logic [7:0]     tx_dat;
  logic [2:0]     gnt_id, err_id;

  uart_tx_sched #(.N(N), .HDR_EN(1'b1), .HDR_TAG(TAG), .TIMEOUT(TO), .TW(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_vld  (req_vld),
    .req_dat  (req_dat),
    .req_last (req_last),
    .req_rdy  (req_rdy),
    .tx_vld   (tx_vld),
    .tx_dat   (tx_dat),
    .tx_bsy   (tx_bsy),
    .gnt_id   (gnt_id),
    .gnt_act  (gnt_act),
    .err_to   (err_to),
    .err_id   (err_id)
  );

  always #5 clk = ~clk;

  int         n_cmp, n_bad, cyc;
  logic [8:0] pbuf [N][16];
  int         ph [N];
  int         pt [N];
  logic [7:0] exp_buf [64];
  int         exp_wr, exp_rd;
  int         txc [64];
  int         tx_n;
  int         rdy_cnt [N];
  int         err_n, err_cyc;
  logic [N-1:0] acc_flag;
  logic       txv_flag, prev_txv, bsy_force;
  int         bsy_len, bsy_cnt;

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s", nm);
  endtask

  task automatic push(input int p, input logic [7:0] b, input logic last);
    pbuf[p][pt[p]] = {last, b};
    pt[p]++;
  endtask

  task automatic expect_b(input logic [7:0] b);
    exp_buf[exp_wr] = b;
    exp_wr++;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (ph[i] < pt[i]) begin
        req_vld[i]         = 1'b1;
        req_last[i]        = pbuf[i][ph[i]][8];
        req_dat[8*i +: 8]  = pbuf[i][ph[i]][7:0];
      end else begin
        req_vld[i]         = 1'b0;
        req_last[i]        = 1'b0;
        req_dat[8*i +: 8]  = 8'h00;
      end
    end
  endtask

  // Advance one clock; retire accepted bytes and model UART_TX's registered bsy
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (acc_flag[i]) ph[i]++;
    if (txv_flag) bsy_cnt = bsy_len;
    else if (bsy_cnt > 0) bsy_cnt--;
    tx_bsy = bsy_force | (bsy_cnt > 0);
    drive();
  endtask

  task automatic monitor();
    cyc++;
    acc_flag = '0;
    if (rst) begin
      chk("rst_quiet", {tx_vld, req_rdy, err_to}, 0);
    end else begin
      for (int i = 0; i < N; i++) begin
        if (req_rdy[i]) begin
          rdy_cnt[i]++;
          chk("rdy_owner", {gnt_act, gnt_id, tx_bsy}, {1'b1, 3'(i), 1'b0});
          if (req_vld[i]) begin
            acc_flag[i] = 1'b1;
            chk("acc_byte", {tx_vld, tx_dat}, {1'b1, req_dat[8*i +: 8]});
          end
        end
      end
      if (tx_vld) begin
        chk("tx_gap", prev_txv, 0);
        chk("tx_while_bsy", tx_bsy, 0);
        if (exp_rd < exp_wr) begin
          chk("tx_dat", tx_dat, exp_buf[exp_rd]);
          exp_rd++;
        end else begin
          fail("tx_unexpected");
        end
        // An issue with no requester accept is a header: it must name the owner
        if (acc_flag == '0)
          chk("hdr_owner", {gnt_act, gnt_id, TAG}, {1'b1, tx_dat[2:0], tx_dat[7:3]});
        if (tx_n < 64) txc[tx_n] = cyc;
        tx_n++;
      end
      if (err_to) begin
        err_n++;
        err_cyc = cyc;
      end
    end
    txv_flag = tx_vld;
    prev_txv = tx_vld;
  endtask

  task automatic do_reset(input bit check);
    rst     = 1'b1;
    bsy_cnt = 0;
    tick();
    tick();
    rst = 1'b0;
    if (check)
      chk("reset_state", {gnt_act, gnt_id, err_id, tx_vld, req_rdy, err_to}, 0);
  endtask

  task automatic wait_done(input int budget, input string nm);
    int k;
    k = 0;
    while (!((exp_rd == exp_wr) && !gnt_act) && k < budget) begin
      tick();
      k++;
    end
    if (k >= budget) fail({nm, "_timeout"});
    else chk(nm, exp_wr - exp_rd, 0);
  endtask

  initial begin
    int s, b, e0, k, r0;
    n_cmp = 0; n_bad = 0; cyc = 0;
    exp_wr = 0; exp_rd = 0; tx_n = 0; err_n = 0; err_cyc = 0;
    acc_flag = '0; txv_flag = 1'b0; prev_txv = 1'b0;
    bsy_force = 1'b0; bsy_len = 0; bsy_cnt = 0; tx_bsy = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin ph[i] = 0; pt[i] = 0; rdy_cnt[i] = 0; end
    drive();
    fork
      forever begin
        @(negedge clk);
        monitor();
      end
    join_none

    // Single packet on port 0, UART never busy
    do_reset(1'b1);
    b = tx_n; r0 = rdy_cnt[0];
    push(0, 8'h41, 1'b0); push(0, 8'h42, 1'b0); push(0, 8'h43, 1'b1);
    expect_b(8'hD0); expect_b(8'h41); expect_b(8'h42); expect_b(8'h43);
    drive(); s = cyc;
    wait_done(40, "t1_done");
    chk("t1_ntx", tx_n - b, 4);
    chk("t1_hdr_cyc", txc[b] - s, 2);
    chk("t1_last_cyc", txc[b+3] - s, 8);
    chk("t1_rdy0_cnt", rdy_cnt[0] - r0, 3);
    $display("t1 port0 packet: %0d bytes issued", tx_n - b);

    // Ports 1 and 3 contend from reset; whole packets, no interleave
    do_reset(1'b0);
    bsy_len = 3; b = tx_n;
    push(1, 8'h11, 1'b0); push(1, 8'h12, 1'b1);
    push(3, 8'h31, 1'b0); push(3, 8'h32, 1'b1);
    expect_b(8'hD1); expect_b(8'h11); expect_b(8'h12);
    expect_b(8'hD3); expect_b(8'h31); expect_b(8'h32);
    drive();
    wait_done(80, "t2_done");
    chk("t2_ntx", tx_n - b, 6);
    $display("t2 ports 1,3: %0d bytes issued", tx_n - b);

    // All four request after port 3 finished: pointer wrapped to 0
    bsy_len = 0; b = tx_n;
    for (int i = 0; i < N; i++) begin
      push(i, 8'(8'h50 + i), 1'b1);
      expect_b(8'(8'hD0 + i));
      expect_b(8'(8'h50 + i));
    end
    drive();
    wait_done(60, "t3_done");
    chk("t3_ntx", tx_n - b, 8);
    $display("t3 wrap order: %0d bytes issued", tx_n - b);

    // Port 2 stalls mid-packet; watchdog hands the line to port 3
    do_reset(1'b0);
    e0 = err_n; b = tx_n;
    push(2, 8'h21, 1'b0);
    push(3, 8'h3A, 1'b1);
    expect_b(8'hD2); expect_b(8'h21); expect_b(8'hD3); expect_b(8'h3A);
    drive(); s = cyc;
    k = 0;
    while (err_n == e0 && k < 60) begin tick(); k++; end
    if (k >= 60) begin
      fail("t4_err_timeout");
    end else begin
      chk("t4_err_id", err_id, 2);
      chk("t4_gnt_act", gnt_act, 0);
      chk("t4_err_lat", err_cyc - txc[b+1], 16);
      chk("t4_err_cyc", err_cyc - s, 20);
    end
    wait_done(40, "t4_done");
    chk("t4_err_once", err_n - e0, 1);
    $display("t4 watchdog: err_id=%0d after %0d cycles", err_id, err_cyc - s);

    // UART busy for 50 cycles during DATA with a byte waiting
    do_reset(1'b0);
    e0 = err_n; b = tx_n;
    push(1, 8'h61, 1'b0); push(1, 8'h62, 1'b1);
    expect_b(8'hD1); expect_b(8'h61); expect_b(8'h62);
    drive(); s = cyc;
    tick();
    bsy_force = 1'b1;
    repeat (50) tick();
    bsy_force = 1'b0;
    wait_done(40, "t5_done");
    chk("t5_issue_cyc", txc[b+1] - s, 53);
    chk("t5_no_err", err_n - e0, 0);
    chk("t5_ntx", tx_n - b, 3);
    $display("t5 bsy stall: first data byte at +%0d", txc[b+1] - s);

    // Reset mid-packet on port 1 while the pointer sits at 2
    b = tx_n;
    push(1, 8'h71, 1'b0); push(1, 8'h72, 1'b0); push(1, 8'h73, 1'b1);
    expect_b(8'hD1); expect_b(8'h71);
    drive();
    k = 0;
    while (tx_n < b + 2 && k < 20) begin tick(); k++; end
    if (k >= 20) fail("t6_pre_timeout");
    rst = 1'b1;
    push(3, 8'h39, 1'b1);
    drive();
    tick();
    rst = 1'b0;
    chk("t6_after_rst", {gnt_act, req_rdy, tx_vld}, 0);
    expect_b(8'hD1); expect_b(8'h72); expect_b(8'h73);
    expect_b(8'hD3); expect_b(8'h39);
    wait_done(60, "t6_done");
    chk("t6_ntx", tx_n - b, 7);
    chk("err_total", err_n, 1);
    $display("t6 reset restart: %0d bytes issued", tx_n - b);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
